// File: rtl/exe_forward_ctrl_pkg.sv
// Shared widths, forwarding-select encodings and FSM states for the EXE-stage hazard/forwarding
// controller and its per-source comparator.
package exe_forward_ctrl_pkg;

    localparam int unsigned REG_ADDR_LEN = 5;
    localparam int unsigned FORW_SEL_LEN = 2;

    localparam logic [FORW_SEL_LEN-1:0] FW_NONE = 2'd0;
    localparam logic [FORW_SEL_LEN-1:0] FW_MEM  = 2'd1;
    localparam logic [FORW_SEL_LEN-1:0] FW_WB   = 2'd2;

    typedef enum logic [1:0] {
        StRun    = 2'd0,
        StBubble = 2'd1,
        StFrozen = 2'd2
    } fsm_state_e;

    // r0 is hard-wired to zero, so it never produces a dependency.
    function automatic logic src_hit(input logic [REG_ADDR_LEN-1:0] src,
                                     input logic [REG_ADDR_LEN-1:0] dest,
                                     input logic                    wb_en);
        return wb_en && (src != '0) && (dest == src);
    endfunction

endpackage

// File: rtl/fw_select_cmp.sv
// Compares one ID-stage source register against the EX and MEM shadows and produces its
// forwarding select plus a dependency flag used for hazard detection. Honours EXE_FORWARDING_EN.
module fw_select_cmp
    import exe_forward_ctrl_pkg::*;
(
    input  logic [REG_ADDR_LEN-1:0] src,
    input  logic                    active,
    input  logic [REG_ADDR_LEN-1:0] ex_dest,
    input  logic                    ex_wb_en,
    input  logic [REG_ADDR_LEN-1:0] mem_dest,
    input  logic                    mem_wb_en,
    output logic [FORW_SEL_LEN-1:0] sel,
    output logic                    hit
);

    logic ex_hit;
    logic mem_hit;

    assign ex_hit  = active && src_hit(src, ex_dest, ex_wb_en);
    assign mem_hit = active && src_hit(src, mem_dest, mem_wb_en);

`ifdef EXE_FORWARDING_EN
    // The EX shadow is the newer producer, so it takes priority over MEM.
    always_comb begin
        sel = FW_NONE;
        if (ex_hit) begin
            sel = FW_MEM;
        end else if (mem_hit) begin
            sel = FW_WB;
        end
    end

    // Only an EX-stage producer can leave a dependency that forwarding cannot cover.
    assign hit = ex_hit;
`else
    assign sel = FW_NONE;
    assign hit = ex_hit | mem_hit;
`endif

endmodule

// File: rtl/exe_forward_ctrl.sv
// EXE-stage hazard and forwarding controller: shadows EX/MEM/WB destinations, registers the
// operand/store forwarding selects and raises load-use stalls. Optional feature: EXE_FORWARDING_EN.
module exe_forward_ctrl
    import exe_forward_ctrl_pkg::*;
#(
    parameter int unsigned CNT_LEN = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    freeze,
    input  logic [REG_ADDR_LEN-1:0] ID_src1,
    input  logic [REG_ADDR_LEN-1:0] ID_src2,
    input  logic [REG_ADDR_LEN-1:0] ID_ST_src,
    input  logic                    ID_two_src,
    input  logic                    ID_is_store,
    input  logic [REG_ADDR_LEN-1:0] ID_dest,
    input  logic                    ID_WB_EN,
    input  logic                    ID_MEM_R_EN,
    output logic [FORW_SEL_LEN-1:0] val1_sel,
    output logic [FORW_SEL_LEN-1:0] val2_sel,
    output logic [FORW_SEL_LEN-1:0] ST_val_sel,
    output logic                    hazard_stall,
    output logic [CNT_LEN-1:0]      stall_count
);

    localparam logic [CNT_LEN-1:0] CntOne = 1;
    localparam logic [CNT_LEN-1:0] CntMax = '1;

    logic [REG_ADDR_LEN-1:0] ex_dest_q, ex_dest_d;
    logic                    ex_wb_en_q, ex_wb_en_d;
    logic                    ex_mem_r_q, ex_mem_r_d;
    logic [REG_ADDR_LEN-1:0] mem_dest_q;
    logic                    mem_wb_en_q;
    logic [REG_ADDR_LEN-1:0] wb_dest_q;
    logic                    wb_wb_en_q;

    logic [FORW_SEL_LEN-1:0] val1_sel_q, val1_sel_d;
    logic [FORW_SEL_LEN-1:0] val2_sel_q, val2_sel_d;
    logic [FORW_SEL_LEN-1:0] st_sel_q, st_sel_d;
    logic [CNT_LEN-1:0]      stall_count_q, stall_count_d;

    fsm_state_e state_q, state_d;
    fsm_state_e held_q, held_d;

    logic [FORW_SEL_LEN-1:0] sel1, sel2, sel_st;
    logic                    hit1, hit2, hit_st;

    fw_select_cmp u_cmp_src1 (
        .src       (ID_src1),
        .active    (1'b1),
        .ex_dest   (ex_dest_q),
        .ex_wb_en  (ex_wb_en_q),
        .mem_dest  (mem_dest_q),
        .mem_wb_en (mem_wb_en_q),
        .sel       (sel1),
        .hit       (hit1)
    );

    fw_select_cmp u_cmp_src2 (
        .src       (ID_src2),
        .active    (ID_two_src),
        .ex_dest   (ex_dest_q),
        .ex_wb_en  (ex_wb_en_q),
        .mem_dest  (mem_dest_q),
        .mem_wb_en (mem_wb_en_q),
        .sel       (sel2),
        .hit       (hit2)
    );

    fw_select_cmp u_cmp_st (
        .src       (ID_ST_src),
        .active    (ID_is_store),
        .ex_dest   (ex_dest_q),
        .ex_wb_en  (ex_wb_en_q),
        .mem_dest  (mem_dest_q),
        .mem_wb_en (mem_wb_en_q),
        .sel       (sel_st),
        .hit       (hit_st)
    );

`ifdef EXE_FORWARDING_EN
    assign hazard_stall = ex_mem_r_q & (hit1 | hit2 | hit_st);
`else
    // Without forwarding every in-flight producer must drain; load status is irrelevant.
    assign hazard_stall = hit1 | hit2 | hit_st;
    logic unused_mem_r;
    assign unused_mem_r = ex_mem_r_q;
`endif

    // WB-stage producers resolve through the register file's write-before-read.
    logic unused_wb;
    assign unused_wb = ^{wb_dest_q, wb_wb_en_q};

    always_comb begin
        ex_dest_d     = ID_dest;
        ex_wb_en_d    = ID_WB_EN;
        ex_mem_r_d    = ID_MEM_R_EN;
        val1_sel_d    = sel1;
        val2_sel_d    = sel2;
        st_sel_d      = sel_st;
        stall_count_d = stall_count_q;
        if (hazard_stall) begin
            ex_dest_d  = '0;
            ex_wb_en_d = 1'b0;
            ex_mem_r_d = 1'b0;
            val1_sel_d = FW_NONE;
            val2_sel_d = FW_NONE;
            st_sel_d   = FW_NONE;
            if (stall_count_q != CntMax) begin
                stall_count_d = stall_count_q + CntOne;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        held_d  = held_q;
        if (freeze) begin
            state_d = StFrozen;
            if (state_q != StFrozen) begin
                held_d = state_q;
            end
        end else if (state_q == StFrozen) begin
            state_d = held_q;
        end else begin
            state_d = hazard_stall ? StBubble : StRun;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StRun;
            held_q  <= StRun;
        end else begin
            state_q <= state_d;
            held_q  <= held_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_dest_q     <= '0;
            ex_wb_en_q    <= 1'b0;
            ex_mem_r_q    <= 1'b0;
            mem_dest_q    <= '0;
            mem_wb_en_q   <= 1'b0;
            wb_dest_q     <= '0;
            wb_wb_en_q    <= 1'b0;
            val1_sel_q    <= FW_NONE;
            val2_sel_q    <= FW_NONE;
            st_sel_q      <= FW_NONE;
            stall_count_q <= '0;
        end else if (!freeze) begin
            ex_dest_q     <= ex_dest_d;
            ex_wb_en_q    <= ex_wb_en_d;
            ex_mem_r_q    <= ex_mem_r_d;
            mem_dest_q    <= ex_dest_q;
            mem_wb_en_q   <= ex_wb_en_q;
            wb_dest_q     <= mem_dest_q;
            wb_wb_en_q    <= mem_wb_en_q;
            val1_sel_q    <= val1_sel_d;
            val2_sel_q    <= val2_sel_d;
            st_sel_q      <= st_sel_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign val1_sel    = val1_sel_q;
    assign val2_sel    = val2_sel_q;
    assign ST_val_sel  = st_sel_q;
    assign stall_count = stall_count_q;

endmodule
